// File: rtl/router_pkg.sv
// Shared types and constants for the router output-port receiver.
package router_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    RECV
  } rx_state_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/router_rx_fifo.sv
// Show-ahead FIFO of rx_entry_t with two ordered push ports and a registered idle head.
module router_rx_fifo
  import router_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_a_i,
  input  rx_entry_t data_a_i,
  input  logic      push_b_i,
  input  rx_entry_t data_b_i,
  input  logic      pop_i,
  output logic      acc_a_o,
  output logic      acc_b_o,
  output rx_entry_t head_o,
  output logic      empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthC = (PtrW+1)'(Depth);

  rx_entry_t         mem_q [Depth];
  rx_entry_t         shown_q;
  logic [PtrW-1:0]   rd_q, rd_d, wr_q, wr_d, wr_b;
  logic [PtrW:0]     cnt_q, cnt_d, space, n_push;
  logic              pop_ok;

  always_comb begin
    empty_o = (cnt_q == '0);
    pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees a slot for this cycle's pushes.
    space   = DepthC - cnt_q + {{PtrW{1'b0}}, pop_ok};
    acc_a_o = push_a_i && (space != '0);
    acc_b_o = push_b_i && (space > {{PtrW{1'b0}}, acc_a_o});
    n_push  = {{PtrW{1'b0}}, acc_a_o} + {{PtrW{1'b0}}, acc_b_o};
    cnt_d   = cnt_q + n_push - {{PtrW{1'b0}}, pop_ok};
    wr_b    = wr_q + {{(PtrW-1){1'b0}}, acc_a_o};
    wr_d    = wr_q + n_push[PtrW-1:0];
    rd_d    = rd_q + {{(PtrW-1){1'b0}}, pop_ok};
    // While empty, keep showing the last head so m_data/m_last hold.
    head_o  = empty_o ? shown_q : mem_q[rd_q];
  end

  always_ff @(posedge clk_i) begin
    if (acc_a_o) mem_q[wr_q] <= data_a_i;
    if (acc_b_o) mem_q[wr_b] <= data_b_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      shown_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (!empty_o) shown_q <= mem_q[rd_q];
    end
  end

endmodule

// File: rtl/router_port_receiver.sv
// Bit-serial to byte-stream receiver for one router output port.
module router_port_receiver
  import router_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dout,
  input  logic              frameo_n,
  input  logic              valido_n,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              err_align,
  output logic              err_ovf,
  output logic              err_proto,
  input  logic              err_clr
);

  rx_state_e         state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d, hold_q, hold_d, new_byte;
  logic              hold_full_q, hold_full_d, byte_done;
  logic [CNT_W-1:0]  pkt_count_q;
  logic              err_align_q, err_ovf_q, err_proto_q;
  logic              set_align, set_proto, cnt_inc;
  logic              push_a, push_b, acc_a, acc_b, empty;
  rx_entry_t         entry_a, entry_b, head;

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    new_byte    = shift_q;
    byte_done   = 1'b0;
    push_a      = 1'b0;
    push_b      = 1'b0;
    entry_a     = '0;
    entry_b     = '0;
    cnt_inc     = 1'b0;
    set_align   = 1'b0;
    set_proto   = 1'b0;
    unique case (state_q)
      SYNC: if (frameo_n) state_d = IDLE;
      IDLE: begin
        if (!frameo_n) begin
          state_d     = RECV;
          bitcnt_d    = 3'd0;
          hold_full_d = 1'b0;
          if (!valido_n) begin
            shift_d[0] = dout;
            bitcnt_d   = 3'd1;
          end
        end else if (!valido_n) begin
          set_proto = 1'b1;
        end
      end
      RECV: begin
        if (!valido_n) begin
          new_byte[bitcnt_q] = dout;
          shift_d            = new_byte;
          bitcnt_d           = bitcnt_q + 3'd1;
          byte_done          = (bitcnt_q == 3'd7);
        end
        if (byte_done) begin
          if (hold_full_q) begin
            push_a  = 1'b1;
            entry_a = '{last: 1'b0, data: hold_q};
          end
          hold_d      = new_byte;
          hold_full_d = 1'b1;
        end
        if (frameo_n) begin
          state_d = IDLE;
          if (hold_full_d) begin
            cnt_inc = 1'b1;
            // A final bit that completes a byte can flush two entries at once.
            if (push_a) begin
              push_b  = 1'b1;
              entry_b = '{last: 1'b1, data: hold_d};
            end else begin
              push_a  = 1'b1;
              entry_a = '{last: 1'b1, data: hold_d};
            end
          end
          set_align   = (bitcnt_d != 3'd0);
          hold_full_d = 1'b0;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SYNC;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      pkt_count_q <= '0;
      err_align_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      if (cnt_inc) pkt_count_q <= pkt_count_q + CNT_W'(1);
      err_align_q <= set_align | (err_align_q & ~err_clr);
      err_ovf_q   <= (push_a & ~acc_a) | (push_b & ~acc_b) | (err_ovf_q & ~err_clr);
      err_proto_q <= set_proto | (err_proto_q & ~err_clr);
    end
  end

  router_rx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .push_a_i (push_a),
    .data_a_i (entry_a),
    .push_b_i (push_b),
    .data_b_i (entry_b),
    .pop_i    (m_ready),
    .acc_a_o  (acc_a),
    .acc_b_o  (acc_b),
    .head_o   (head),
    .empty_o  (empty)
  );

  assign m_data    = head.data;
  assign m_last    = head.last;
  assign m_valid   = !empty;
  assign pkt_count = pkt_count_q;
  assign err_align = err_align_q;
  assign err_ovf   = err_ovf_q;
  assign err_proto = err_proto_q;

endmodule

// File: tb/tb_router_port_receiver.sv
// Directed bench for router_port_receiver: table of packets plus multi-cycle corner sequences.
module tb_router_port_receiver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dout = 1'b0;
  logic        frameo_n = 1'b1;
  logic        valido_n = 1'b1;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] pkt_count;
  logic        err_align, err_ovf, err_proto;
  logic        err_clr = 1'b0;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [8:0] cap[$];

  always #5 clk = ~clk;

  router_port_receiver #(
    .FIFO_DEPTH (4),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dout      (dout),
    .frameo_n  (frameo_n),
    .valido_n  (valido_n),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .pkt_count (pkt_count),
    .err_align (err_align),
    .err_ovf   (err_ovf),
    .err_proto (err_proto),
    .err_clr   (err_clr)
  );

  // Record every accepted handshake with the values present before the edge.
  always @(posedge clk) if (reset_n && m_valid && m_ready) cap.push_back({m_last, m_data});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_pkt(input logic [31:0] bytes, input int nbytes, input int nextra,
                          input logic [7:0] extra, input bit gap, input bit trail);
    bit bq[$];
    for (int i = 0; i < nbytes; i++)
      for (int j = 0; j < 8; j++) bq.push_back(bytes[8*i+j]);
    for (int j = 0; j < nextra; j++) bq.push_back(extra[j]);
    for (int k = 0; k < bq.size(); k++) begin
      if (gap && (k % 3 == 2)) begin
        frameo_n = 1'b0; valido_n = 1'b1; dout = 1'b1;
        @(negedge clk);
      end
      frameo_n = (k == bq.size() - 1);
      valido_n = 1'b0;
      dout     = bq[k];
      @(negedge clk);
    end
    frameo_n = 1'b1; valido_n = 1'b1; dout = 1'b0;
    if (trail) @(negedge clk);
  endtask

  task automatic pop_check(input string name, input logic [7:0] d, input logic l);
    int n = 0;
    logic [8:0] e;
    m_ready = 1'b1;
    while (cap.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    m_ready = 1'b0;
    if (cap.size() == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    else begin
      e = cap.pop_front();
      chk({name, "_data"}, {24'd0, e[7:0]}, {24'd0, d});
      chk({name, "_last"}, {31'd0, e[8]}, {31'd0, l});
    end
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          nbytes;
    int          nextra;
    logic [7:0]  extra;
    bit          gap;
    bit          exp_align;
    int          exp_inc;
  } vec_t;

  vec_t vecs[4];
  logic [8:0] e;

  initial begin
    vecs[0] = '{bytes: 32'h0000_3CA5, nbytes: 2, nextra: 0, extra: 8'h00, gap: 1'b1,
                exp_align: 1'b0, exp_inc: 1};
    vecs[1] = '{bytes: 32'h0000_000F, nbytes: 1, nextra: 3, extra: 8'h05, gap: 1'b0,
                exp_align: 1'b1, exp_inc: 1};
    vecs[2] = '{bytes: 32'h0000_0000, nbytes: 0, nextra: 5, extra: 8'h1B, gap: 1'b1,
                exp_align: 1'b1, exp_inc: 0};
    vecs[3] = '{bytes: 32'h007E_81C3, nbytes: 3, nextra: 0, extra: 8'h00, gap: 1'b0,
                exp_align: 1'b0, exp_inc: 1};

    #12 reset_n = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    chk("rst_last", {31'd0, m_last}, 32'd0);
    chk("rst_count", {16'd0, pkt_count}, 32'd0);
    chk("rst_errs", {29'd0, err_align, err_ovf, err_proto}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      send_pkt(vecs[v].bytes, vecs[v].nbytes, vecs[v].nextra, vecs[v].extra, vecs[v].gap, 1'b1);
      exp_cnt += vecs[v].exp_inc;
      chk($sformatf("v%0d_align", v), {31'd0, err_align}, {31'd0, vecs[v].exp_align});
      chk($sformatf("v%0d_count", v), {16'd0, pkt_count}, exp_cnt);
      for (int i = 0; i < vecs[v].nbytes; i++)
        pop_check($sformatf("v%0d_b%0d", v, i), vecs[v].bytes[8*i +: 8],
                  (i == vecs[v].nbytes - 1));
      @(negedge clk);
      chk($sformatf("v%0d_empty", v), {31'd0, m_valid}, 32'd0);
      chk($sformatf("v%0d_ovf_proto", v), {30'd0, err_ovf, err_proto}, 32'd0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
    end

    // Overflow: six bytes into a four-entry FIFO with no consumer.
    send_pkt(32'h0403_0201, 4, 16, 8'h05, 1'b0, 1'b0);
    exp_cnt += 1;
    @(negedge clk);
    chk("ovf_flag", {31'd0, err_ovf}, 32'd1);
    chk("ovf_count", {16'd0, pkt_count}, exp_cnt);
    chk("ovf_align", {31'd0, err_align}, 32'd0);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovf_b%0d", i), i[7:0], 1'b0);
    @(negedge clk);
    chk("ovf_drained", {31'd0, m_valid}, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovf_cleared", {31'd0, err_ovf}, 32'd0);

    // Stray bit while idle, with a clear in the same cycle: the set must win.
    frameo_n = 1'b1; valido_n = 1'b0; dout = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    valido_n = 1'b1; err_clr = 1'b0; dout = 1'b0;
    chk("proto_flag", {31'd0, err_proto}, 32'd1);
    @(negedge clk);
    chk("proto_empty", {31'd0, m_valid}, 32'd0);

    // Back-to-back packets with the consumer always ready.
    m_ready = 1'b1;
    send_pkt(32'h0000_0011, 1, 0, 8'h00, 1'b0, 1'b0);
    send_pkt(32'h0000_3322, 2, 0, 8'h00, 1'b0, 1'b1);
    exp_cnt += 2;
    repeat (4) @(negedge clk);
    m_ready = 1'b0;
    chk("b2b_npops", cap.size(), 32'd3);
    chk("b2b_count", {16'd0, pkt_count}, exp_cnt);
    if (cap.size() == 3) begin
      e = cap.pop_front(); chk("b2b_0", {23'd0, e}, 32'h111);
      e = cap.pop_front(); chk("b2b_1", {23'd0, e}, 32'h022);
      e = cap.pop_front(); chk("b2b_2", {23'd0, e}, 32'h133);
    end
    chk("hold_data", {24'd0, m_data}, 32'h33);
    chk("hold_last", {31'd0, m_last}, 32'd1);

    // Reset in the middle of the second byte, released while the frame is still low.
    for (int k = 0; k < 11; k++) begin
      frameo_n = 1'b0; valido_n = 1'b0; dout = (k < 8) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, m_data}, 32'd0);
    chk("mid_rst_last", {31'd0, m_last}, 32'd0);
    chk("mid_rst_count", {16'd0, pkt_count}, 32'd0);
    chk("mid_rst_errs", {29'd0, err_align, err_ovf, err_proto}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_cnt = 0;
    for (int k = 0; k < 13; k++) begin
      frameo_n = (k == 12); valido_n = 1'b0; dout = k[0];
      @(negedge clk);
    end
    frameo_n = 1'b1; valido_n = 1'b1; dout = 1'b0;
    @(negedge clk);
    chk("sync_empty", {31'd0, m_valid}, 32'd0);
    chk("sync_count", {16'd0, pkt_count}, 32'd0);
    chk("sync_errs", {29'd0, err_align, err_ovf, err_proto}, 32'd0);
    send_pkt(32'h0000_005A, 1, 0, 8'h00, 1'b1, 1'b1);
    exp_cnt += 1;
    pop_check("post_rst", 8'h5A, 1'b1);
    chk("post_rst_count", {16'd0, pkt_count}, exp_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/router_port_receiver.md
# router_port_receiver

Deserializer for one router output port. Reassembles the bit-serial `dout`/`frameo_n`/`valido_n` stream into bytes, LSB first, and buffers them in a small FIFO. It presents them as a valid/ready byte stream with an end-of-packet flag. One instance sits on each of the 16 router output ports, as the byte-level consumer and scoreboard source for the router.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: byte entries in the output FIFO; must be a power of 2, at least 4.
- `CNT_W`, 16: width of the packet counter.

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `dout` in 1: serial data bit from the router output port.
- `frameo_n` in 1: active-low frame from the router; high on the final bit of a packet.
- `valido_n` in 1: active-low; `dout` carries a payload bit this cycle.
- `m_data` out 8: byte at the FIFO head.
- `m_last` out 1: the head byte is the final byte of its packet.
- `m_valid` out 1: the FIFO is non-empty.
- `m_ready` in 1: consumer accepts the head byte when `m_valid` and `m_ready` are both high.
- `pkt_count` out CNT_W: packets terminated with at least one byte; wraps at 2^CNT_W.
- `err_align` out 1: sticky; a packet ended with 1–7 leftover bits.
- `err_ovf` out 1: sticky; a byte was dropped because the FIFO was full.
- `err_proto` out 1: sticky; a valid bit arrived outside any packet.
- `err_clr` in 1: synchronous clear of all three sticky error flags.

## Operation
- The FSM has three states: SYNC, IDLE and RECV. Reset enters SYNC.
- SYNC: wait until `frameo_n`=1 is sampled, then go to IDLE. This discards any packet already in flight when reset deasserts.
- IDLE: `frameo_n`=0 goes to RECV, clears the bit counter and the holding register is empty.
  - If `valido_n`=0 in that same cycle, the bit is captured as bit 0.
  - `valido_n`=0 with `frameo_n`=1 sets `err_proto` and the bit is ignored.
- RECV, cycle with `valido_n`=1: pad/gap cycle, nothing captured.
- RECV, cycle with `valido_n`=0: shift `dout` into bit position `bitcnt` and increment the 3-bit counter.
  - On the 8th bit the byte is complete.
  - If the holding register is full, push its contents with last=0.
  - The new byte then enters the holding register.
- End of packet: any RECV cycle sampling `frameo_n`=1, including that cycle's bit if `valido_n`=0.
  - After capturing that bit, push the holding register (if full) with last=1 and increment `pkt_count`.
  - If `bitcnt`≠0, discard the partial bits and set `err_align`.
  - A packet with no complete byte pushes nothing and does not count.
  - Return to IDLE.
- Push when FIFO full:
  - If the same cycle pops (`m_ready`&`m_valid`), the push succeeds.
  - Otherwise drop the byte and set `err_ovf`.
  - A dropped last byte still counts the packet.
- `err_clr` in the same cycle as a new error event: the set wins.
- Bit order: the first captured bit is `m_data[0]`.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `pkt_count`=0, all error flags 0, FSM=SYNC, FIFO empty.
- Latency, non-final byte: reaches the FIFO on the clock edge that completes the next byte. The holding register delays the stream by exactly one byte.
- Latency, final byte: pushed on the edge that samples `frameo_n`=1.
- FIFO is show-ahead: `m_valid`, `m_data` and `m_last` are valid the cycle after a push into an empty FIFO.
- Pop and push in the same cycle are both honoured, so occupancy is unchanged.
- `m_data`/`m_last` hold their last values while `m_valid`=0.
- Back-to-back packets: `frameo_n` may return low the cycle after the end cycle; IDLE accepts it with no gap.
- The block cannot backpressure the router; `m_ready` affects only the FIFO.

## Structure
- `router_pkg` (shared) holds:
  - `BYTE_W`=8.
  - `rx_state_e` {SYNC, IDLE, RECV}.
  - `rx_entry_t` struct {logic last; logic [7:0] data}.
- One sub-module, `router_rx_fifo`: a synchronous show-ahead FIFO of `rx_entry_t`, parameterised by depth. It provides push/pop, full/empty and the simultaneous-full push/pop rule.
- Top level contains the FSM, shift register, bit counter, holding register, counter and error flags.

## Test plan
- Basic packet: pads, then bytes 0xA5, 0x3C sent LSB first, `frameo_n` high on the last bit. Required: two pops 0xA5/last=0 then 0x3C/last=1; `pkt_count`=1; no error flags.
- Misaligned end: 8 bits of 0x0F then 3 more bits, then end. Required: one pop 0x0F/last=1; `err_align`=1; `pkt_count`=1.
- Overflow with FIFO_DEPTH=4: `m_ready`=0, 6-byte packet 0x01..0x06. Required: FIFO holds 0x01..0x04; `err_ovf`=1; `pkt_count`=1. `err_clr` then clears the flag.
- Back-to-back packets: packet {0x11}, then `frameo_n` low the next cycle for packet {0x22, 0x33}, `m_ready`=1 throughout. Required: 0x11/1, 0x22/0, 0x33/1; `pkt_count`=2.
- Reset mid-packet: assert `reset_n` during byte 2, release while `frameo_n` is still low. Required: all outputs return to reset values; the remainder of the packet is ignored; the next full packet {0x5A} is received correctly.
- Stray bit: `valido_n`=0 with `frameo_n`=1 while IDLE. Required: `err_proto`=1, FIFO stays empty.
